// File: rtl/exec_md_stage.sv
// exec_md_stage: execute stage with a W-bit ALU, operand forwarding, a load-hazard
// stall and an iterative multiply/divide unit. The registered result feeds the
// memory stage and the forwarding network.
// Build option: define EXEC_DIV_EN to include the iterative divider (ops 10/11);
// without it, ops 10/11 complete in one cycle with a zero result.
module exec_md_stage #(
    parameter int W    = 32,
    parameter int NFWD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               halt,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [3:0]         op,
    input  logic [4:0]         s1,
    input  logic [4:0]         s2,
    input  logic [4:0]         tgt,
    input  logic               use_imm,
    input  logic [W-1:0]       imm,
    input  logic [W-1:0]       reg_a,
    input  logic [W-1:0]       reg_b,
    input  logic [NFWD-1:0]    fwd_valid,
    input  logic [NFWD-1:0]    fwd_pending,
    input  logic [5*NFWD-1:0]  fwd_tgt,
    input  logic [W*NFWD-1:0]  fwd_data,
    output logic               stall,
    output logic               out_valid,
    output logic [4:0]         out_tgt,
    output logic [W-1:0]       out_result,
    output logic [3:0]         out_flags
);

    localparam int LW = $clog2(W);
    localparam logic [LW-1:0] LAST = LW'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;     // mul: product high half; div: partial remainder
    logic [W-1:0]  lo_q, lo_d;       // mul: multiplier / product low; div: dividend / quotient
    logic [W-1:0]  dsr_q, dsr_d;     // multiplicand or divisor
    logic          hi_q, hi_d;       // result comes from acc (mulhu/remu) rather than lo
    logic [4:0]    mtgt_q, mtgt_d;
`ifdef EXEC_DIV_EN
    logic          div_q, div_d;
`endif
    logic          out_valid_q, out_valid_d;
    logic [4:0]    out_tgt_q, out_tgt_d;
    logic [W-1:0]  out_result_q, out_result_d;
    logic [3:0]    out_flags_q, out_flags_d;

    logic [W-1:0]  opa, opb, rhs;
    logic          haz, hit_a, hit_b;

    // Operand selection (own output > port 0 .. port NFWD-1 > register file) and load hazard
    always_comb begin
        opa   = reg_a;
        opb   = reg_b;
        hit_a = 1'b0;
        hit_b = 1'b0;
        haz   = 1'b0;
        for (int unsigned k = 0; k < NFWD; k++) begin
            if (!hit_a && fwd_valid[k] && fwd_tgt[5*k +: 5] == s1) begin
                opa   = fwd_data[W*k +: W];
                hit_a = 1'b1;
            end
            if (!hit_b && fwd_valid[k] && fwd_tgt[5*k +: 5] == s2) begin
                opb   = fwd_data[W*k +: W];
                hit_b = 1'b1;
            end
            if (fwd_valid[k] && fwd_pending[k] &&
                ((s1 != 5'd0 && fwd_tgt[5*k +: 5] == s1) ||
                 (s2 != 5'd0 && fwd_tgt[5*k +: 5] == s2)))
                haz = 1'b1;
        end
        if (out_valid_q && out_tgt_q == s1) opa = out_result_q;
        if (out_valid_q && out_tgt_q == s2) opb = out_result_q;
        if (s1 == 5'd0) opa = reg_a;
        if (s2 == 5'd0) opb = reg_b;
    end

    assign rhs = use_imm ? imm : opb;

    logic [LW-1:0]       shamt;
    logic [W:0]          sum_ext, dif_ext, shl_ext, shr_ext;
    logic signed [W:0]   sra_ext;
    logic [W-1:0]        alu_res;
    logic                alu_c, alu_o;
    logic [3:0]          alu_flags;

    // Extra bit on each shifter catches the last bit shifted out
    assign shamt   = rhs[LW-1:0];
    assign sum_ext = {1'b0, opa} + {1'b0, rhs};
    assign dif_ext = {1'b0, opa} + {1'b0, ~rhs} + {{W{1'b0}}, 1'b1};
    assign shl_ext = {1'b0, opa} << shamt;
    assign shr_ext = {opa, 1'b0} >> shamt;
    assign sra_ext = $signed({opa, 1'b0}) >>> shamt;

    // Single-cycle ALU result and flags
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        case (op)
            4'd0: begin
                alu_res = sum_ext[W-1:0];
                alu_c   = sum_ext[W];
                alu_o   = (opa[W-1] == rhs[W-1]) && (alu_res[W-1] != opa[W-1]);
            end
            4'd1: begin
                alu_res = dif_ext[W-1:0];
                alu_c   = dif_ext[W];
                alu_o   = (opa[W-1] != rhs[W-1]) && (alu_res[W-1] != opa[W-1]);
            end
            4'd2: alu_res = opa & rhs;
            4'd3: alu_res = opa | rhs;
            4'd4: alu_res = opa ^ rhs;
            4'd5: begin alu_res = shl_ext[W-1:0]; alu_c = shl_ext[W]; end
            4'd6: begin alu_res = shr_ext[W:1];   alu_c = shr_ext[0]; end
            4'd7: begin alu_res = sra_ext[W:1];   alu_c = sra_ext[0]; end
            default: ;
        endcase
        alu_flags = {alu_o, alu_res[W-1], alu_res == '0, alu_c};
    end

    logic is_iter;
`ifdef EXEC_DIV_EN
    assign is_iter = (op >= 4'd8) && (op <= 4'd11);
`else
    assign is_iter = (op == 4'd8) || (op == 4'd9);
`endif

    logic [W:0]   mul_sum;
    logic [W-1:0] fin_res;
    assign mul_sum = {1'b0, acc_q} + ({1'b0, dsr_q} & {(W+1){lo_q[0]}});
    assign fin_res = hi_q ? acc_q : lo_q;

`ifdef EXEC_DIV_EN
    logic [W:0]   div_rem;
    logic [W-1:0] div_dif;
    logic         div_ge;
    // Remainder stays below the divisor, so the difference always fits in W bits
    assign div_rem = {acc_q, lo_q[W-1]};
    assign div_ge  = div_rem >= {1'b0, dsr_q};
    assign div_dif = div_rem[W-1:0] - dsr_q;
`endif

    // FSM next state, mul/div datapath step, stall and output-register next values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        lo_d         = lo_q;
        dsr_d        = dsr_q;
        hi_d         = hi_q;
        mtgt_d       = mtgt_q;
`ifdef EXEC_DIV_EN
        div_d        = div_q;
`endif
        out_valid_d  = 1'b0;
        out_tgt_d    = '0;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        stall        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (haz) begin
                        stall = 1'b1;
                    end else if (is_iter) begin
                        stall   = 1'b1;
                        acc_d   = '0;
                        lo_d    = opa;
                        dsr_d   = rhs;
                        hi_d    = op[0];
`ifdef EXEC_DIV_EN
                        div_d   = op[1];
`endif
                        mtgt_d  = tgt;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end else begin
                        out_valid_d  = 1'b1;
                        out_tgt_d    = tgt;
                        out_result_d = alu_res;
                        out_flags_d  = alu_flags;
                    end
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + LW'(1);
`ifdef EXEC_DIV_EN
                if (div_q) begin
                    acc_d = div_ge ? div_dif : div_rem[W-1:0];
                    lo_d  = {lo_q[W-2:0], div_ge};
                end else
`endif
                begin
                    acc_d = mul_sum[W:1];
                    lo_d  = {mul_sum[0], lo_q[W-1:1]};
                end
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                out_valid_d  = 1'b1;
                out_tgt_d    = mtgt_q;
                out_result_d = fin_res;
                out_flags_d  = {1'b0, fin_res[W-1], fin_res == '0, 1'b0};
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_tgt_d   = '0;
        end
    end

    // State and output registers; halt freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            lo_q         <= '0;
            dsr_q        <= '0;
            hi_q         <= 1'b0;
            mtgt_q       <= '0;
`ifdef EXEC_DIV_EN
            div_q        <= 1'b0;
`endif
            out_valid_q  <= 1'b0;
            out_tgt_q    <= '0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else if (!halt) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            lo_q         <= lo_d;
            dsr_q        <= dsr_d;
            hi_q         <= hi_d;
            mtgt_q       <= mtgt_d;
`ifdef EXEC_DIV_EN
            div_q        <= div_d;
`endif
            out_valid_q  <= out_valid_d;
            out_tgt_q    <= out_tgt_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_tgt    = out_tgt_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule
